alsu_op_issuer: RTL and testbench

- Initiator-side driver for the ALSU datapath.
- Accepts ALSU operation commands over a valid/ready stream and drives them onto the ALSU input pins, at most one per cycle.
- Tracks each operation through the ALSU's fixed pipeline latency, then captures alsu_out/alsu_leds into an in-order response FIFO.
- Used as the bus-functional front end in block/system benches and as the production sequencer feeding the ALSU.

---
 rtl/alsu_pkg.sv | 41 ++++
 rtl/alsu_rsp_fifo.sv | 67 ++++++
 rtl/alsu_op_issuer.sv | 118 +++++++++++
 tb/tb_alsu_op_issuer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alsu_pkg.sv
// Shared types and helpers for the ALSU operation issuer.
// Command/response bundles plus opcode encodings.
package alsu_pkg;

    localparam int W_IN   = 3;
    localparam int W_OUT  = 6;
    localparam int W_LEDS = 16;

    localparam logic [2:0] OP_OR     = 3'd0;
    localparam logic [2:0] OP_XOR    = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_MULT   = 3'd3;
    localparam logic [2:0] OP_SHIFT  = 3'd4;
    localparam logic [2:0] OP_ROTATE = 3'd5;

    typedef struct packed {
        logic [W_IN-1:0] A;
        logic [W_IN-1:0] B;
        logic [2:0]      opcode;
        logic            cin;
        logic            serial_in;
        logic            direction;
        logic            red_op_A;
        logic            red_op_B;
        logic            bypass_A;
        logic            bypass_B;
    } alsu_cmd_t;

    typedef struct packed {
        logic [W_OUT-1:0]  out;
        logic [W_LEDS-1:0] leds;
        logic              invalid;
    } alsu_rsp_t;

    // Reductions only make sense for OR/XOR; opcodes 6/7 are undefined.
    function automatic logic is_invalid(input alsu_cmd_t c);
        return ((c.red_op_A | c.red_op_B) & (c.opcode[1] | c.opcode[2]))
             | (c.opcode[1] & c.opcode[2]);
    endfunction

endpackage

// File: rtl/alsu_rsp_fifo.sv
// In-order response FIFO with occupancy count.
// Push when full is dropped; pop when empty is ignored.
module alsu_rsp_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full || rd_en);
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    always_comb begin
        wptr_d  = wr_en ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = rd_en ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/alsu_op_issuer.sv
// Drives ALSU commands onto the pins, tracks pipeline latency
// and collects results in order into a credit-limited FIFO.
module alsu_op_issuer
    import alsu_pkg::*;
#(
    parameter int WIDTH_IN  = W_IN,
    parameter int WIDTH_OUT = W_OUT,
    parameter int LEDS_W    = W_LEDS,
    parameter int LATENCY   = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  alsu_cmd_t            cmd,
    output logic                 alsu_rst,
    output logic [WIDTH_IN-1:0]  alsu_A,
    output logic [WIDTH_IN-1:0]  alsu_B,
    output logic [2:0]           alsu_opcode,
    output logic [6:0]           alsu_ctrl,
    input  logic [WIDTH_OUT-1:0] alsu_out,
    input  logic [LEDS_W-1:0]    alsu_leds,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output alsu_rsp_t            rsp
);

    localparam int FCW = $clog2(RSP_DEPTH + 1);
    localparam int OCW = $clog2(RSP_DEPTH + LATENCY + 2) + 1;

    logic            sync_q;
    logic            alsu_rst_q;
    alsu_cmd_t       pins_q, pins_d;
    logic [LATENCY:0] trk_v_q, trk_v_d;
    logic [LATENCY:0] trk_inv_q, trk_inv_d;
    logic [OCW-1:0]  inflight;
    logic [OCW-1:0]  occupancy;
    logic [FCW-1:0]  fifo_cnt;
    logic            fifo_empty;
    logic            accept;
    alsu_rsp_t       cap;

    // Async assert, two-edge synchronised release of the ALSU reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 1'b0;
            alsu_rst_q <= 1'b1;
        end else begin
            sync_q     <= 1'b1;
            alsu_rst_q <= !sync_q;
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= LATENCY; i++) begin
            inflight = inflight + OCW'(trk_v_q[i]);
        end
    end

    assign occupancy = inflight + OCW'(fifo_cnt);
    assign cmd_ready = !alsu_rst_q && (occupancy < OCW'(RSP_DEPTH));
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        pins_d       = accept ? cmd : '0;
        trk_v_d      = '0;
        trk_inv_d    = '0;
        trk_v_d[0]   = accept;
        trk_inv_d[0] = accept && is_invalid(cmd);
        for (int i = 1; i <= LATENCY; i++) begin
            trk_v_d[i]   = trk_v_q[i-1];
            trk_inv_d[i] = trk_inv_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pins_q    <= '0;
            trk_v_q   <= '0;
            trk_inv_q <= '0;
        end else begin
            pins_q    <= pins_d;
            trk_v_q   <= trk_v_d;
            trk_inv_q <= trk_inv_d;
        end
    end

    assign alsu_rst    = alsu_rst_q;
    assign alsu_A      = pins_q.A;
    assign alsu_B      = pins_q.B;
    assign alsu_opcode = pins_q.opcode;
    assign alsu_ctrl   = {pins_q.cin, pins_q.serial_in, pins_q.direction,
                          pins_q.red_op_A, pins_q.red_op_B,
                          pins_q.bypass_A, pins_q.bypass_B};

    assign cap.out     = alsu_out;
    assign cap.leds    = alsu_leds;
    assign cap.invalid = trk_inv_q[LATENCY];

    alsu_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH ($bits(alsu_rsp_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (trk_v_q[LATENCY]),
        .wdata_i (cap),
        .pop_i   (rsp_ready),
        .rdata_o (rsp),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign rsp_valid = !fifo_empty;

endmodule

// File: tb/tb_alsu_op_issuer.sv
// Directed bench for alsu_op_issuer with a behavioural ALSU model.
// Table-driven single ops plus multi-cycle corner sequences.
module tb_alsu_op_issuer;
    import alsu_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      cmd_valid;
    logic      cmd_ready;
    alsu_cmd_t cmd;
    logic      alsu_rst;
    logic [2:0] alsu_A, alsu_B, alsu_opcode;
    logic [6:0] alsu_ctrl;
    logic [5:0] alsu_out;
    logic [15:0] alsu_leds;
    logic      rsp_valid;
    logic      rsp_ready;
    alsu_rsp_t rsp;

    int n_chk;
    int n_fail;

    alsu_op_issuer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd         (cmd),
        .alsu_rst    (alsu_rst),
        .alsu_A      (alsu_A),
        .alsu_B      (alsu_B),
        .alsu_opcode (alsu_opcode),
        .alsu_ctrl   (alsu_ctrl),
        .alsu_out    (alsu_out),
        .alsu_leds   (alsu_leds),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp         (rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALSU: inputs registered, output registered one edge later.
    logic [2:0] mA, mB, mop;
    logic [6:0] mctl;
    logic       minv;

    function automatic logic [5:0] alu(input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] op, input logic [6:0] c,
                                       input logic [5:0] prev);
        logic [5:0] ea;
        logic [5:0] eb;
        ea = {{3{a[2]}}, a};
        eb = {{3{b[2]}}, b};
        if (c[1]) return ea;
        if (c[0]) return eb;
        case (op)
            OP_OR:     return c[3] ? {5'b0, |a} : c[2] ? {5'b0, |b} : (ea | eb);
            OP_XOR:    return c[3] ? {5'b0, ^a} : c[2] ? {5'b0, ^b} : (ea ^ eb);
            OP_ADD:    return ea + eb + {5'b0, c[6]};
            OP_MULT:   return ea * eb;
            OP_SHIFT:  return c[4] ? {prev[4:0], c[5]} : {c[5], prev[5:1]};
            OP_ROTATE: return c[4] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
            default:   return 6'd0;
        endcase
    endfunction

    assign minv = ((mctl[3] | mctl[2]) & (mop[1] | mop[2])) | (mop[1] & mop[2]);

    always @(posedge clk or posedge alsu_rst) begin
        if (alsu_rst) begin
            mA <= '0; mB <= '0; mop <= '0; mctl <= '0;
            alsu_out <= '0; alsu_leds <= '0;
        end else begin
            mA <= alsu_A; mB <= alsu_B; mop <= alsu_opcode; mctl <= alsu_ctrl;
            if (minv) begin
                alsu_out  <= '0;
                alsu_leds <= ~alsu_leds;
            end else begin
                alsu_out  <= alu(mA, mB, mop, mctl, alsu_out);
                alsu_leds <= '0;
            end
        end
    end

    typedef struct {
        alsu_cmd_t   c;
        logic [5:0]  o;
        logic [15:0] l;
        logic        i;
    } vec_t;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_CIN  = 7'b1000000;
    localparam logic [6:0] C_REDA = 7'b0001000;
    localparam logic [6:0] C_REDB = 7'b0000100;
    localparam logic [6:0] C_BYPA = 7'b0000010;
    localparam logic [6:0] C_BYPB = 7'b0000001;

    function automatic alsu_cmd_t mk(input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] op, input logic [6:0] ct);
        return {a, b, op, ct};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input alsu_cmd_t c);
        int n;
        cmd       = c;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        cmd       = '0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    vec_t       tv[9];
    alsu_cmd_t  q4[6];
    logic [5:0] e4[6];

    initial begin
        int lat, idx, got, stale;
        logic rdy, rv;
        logic [5:0] ro;

        n_chk = 0;
        n_fail = 0;
        tv[0] = '{mk(3'd3, 3'd2, OP_ADD, C_CIN), 6'h06, 16'h0000, 1'b0};
        tv[1] = '{mk(3'd1, 3'd2, OP_OR, C_NONE), 6'h03, 16'h0000, 1'b0};
        tv[2] = '{mk(3'd3, 3'd1, OP_XOR, C_NONE), 6'h02, 16'h0000, 1'b0};
        tv[3] = '{mk(3'b100, 3'd0, OP_OR, C_REDA), 6'h01, 16'h0000, 1'b0};
        tv[4] = '{mk(3'd0, 3'b111, OP_XOR, C_REDB), 6'h01, 16'h0000, 1'b0};
        tv[5] = '{mk(3'd3, 3'b111, OP_MULT, C_NONE), 6'h3D, 16'h0000, 1'b0};
        tv[6] = '{mk(3'd1, 3'b110, OP_ADD, C_BYPB), 6'h3E, 16'h0000, 1'b0};
        tv[7] = '{mk(3'd1, 3'd1, OP_ADD, C_REDA), 6'h00, 16'hFFFF, 1'b1};
        tv[8] = '{mk(3'd1, 3'd1, 3'd7, C_NONE), 6'h00, 16'hFFFF, 1'b1};
        for (int k = 0; k < 6; k++) begin
            logic [2:0] a;
            a = (k < 3) ? 3'(k + 1) : 3'(10 - k);
            q4[k] = mk(a, 3'd0, OP_ADD, C_NONE);
            e4[k] = {{3{a[2]}}, a};
        end

        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd = '0;
        rsp_ready = 1'b0;
        #12;
        chk("rst_alsu_rst", 32'(alsu_rst), 32'd1);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_pins", 32'({alsu_A, alsu_B, alsu_opcode, alsu_ctrl}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel_edge1", 32'(alsu_rst), 32'd1);
        tick();
        chk("rel_edge2", 32'(alsu_rst), 32'd0);
        chk("ready_after_rel", 32'(cmd_ready), 32'd1);

        rsp_ready = 1'b1;
        for (int v = 0; v < 9; v++) begin
            send(tv[v].c);
            wait_rsp(lat);
            chk($sformatf("v%0d_lat", v), 32'(lat), 32'd3);
            chk($sformatf("v%0d_out", v), 32'(rsp.out), 32'(tv[v].o));
            chk($sformatf("v%0d_leds", v), 32'(rsp.leds), 32'(tv[v].l));
            chk($sformatf("v%0d_inv", v), 32'(rsp.invalid), 32'(tv[v].i));
            tick();
            chk($sformatf("v%0d_drain", v), 32'(rsp_valid), 32'd0);
            tick();
        end

        // Back-to-back MULT then bypass_A.
        cmd = mk(3'b100, 3'b100, OP_MULT, C_NONE);
        cmd_valid = 1'b1;
        tick();
        cmd = mk(3'b101, 3'd2, OP_ADD, C_BYPA);
        tick();
        cmd_valid = 1'b0;
        cmd = '0;
        wait_rsp(lat);
        chk("b2b_first", 32'(rsp.out), 32'h10);
        tick();
        chk("b2b_valid2", 32'(rsp_valid), 32'd1);
        chk("b2b_second", 32'(rsp.out), 32'h3D);
        tick();

        // Invalid op then valid ADD: leds toggle then clear.
        cmd = mk(3'd1, 3'd1, 3'd6, C_NONE);
        cmd_valid = 1'b1;
        tick();
        cmd = mk(3'd1, 3'd1, OP_ADD, C_NONE);
        tick();
        cmd_valid = 1'b0;
        cmd = '0;
        wait_rsp(lat);
        chk("inv_flag", 32'(rsp.invalid), 32'd1);
        chk("inv_leds", 32'(rsp.leds), 32'hFFFF);
        tick();
        chk("add_flag", 32'(rsp.invalid), 32'd0);
        chk("add_leds", 32'(rsp.leds), 32'h0000);
        chk("add_out", 32'(rsp.out), 32'h02);
        tick();

        // Credit limit with consumer stalled, then drain.
        rsp_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 10; k++) begin
            cmd = q4[(idx < 6) ? idx : 0];
            cmd_valid = (idx < 6);
            rdy = cmd_ready;
            tick();
            if (cmd_valid && rdy) idx++;
        end
        chk("credit_accepted", 32'(idx), 32'd4);
        chk("credit_ready", 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 60 && got < 6; k++) begin
            cmd = q4[(idx < 6) ? idx : 0];
            cmd_valid = (idx < 6);
            rdy = cmd_ready;
            rv = rsp_valid;
            ro = rsp.out;
            tick();
            if (rv) begin
                chk($sformatf("drain%0d", got), 32'(ro), 32'(e4[got]));
                got++;
            end
            if (cmd_valid && rdy) idx++;
        end
        cmd_valid = 1'b0;
        cmd = '0;
        chk("drain_count", 32'(got), 32'd6);
        chk("drain_accepted", 32'(idx), 32'd6);

        // Async reset with work in flight and in the FIFO.
        rsp_ready = 1'b0;
        send(mk(3'd1, 3'd0, OP_ADD, C_NONE));
        wait_rsp(lat);
        chk("pre_rst_fifo", 32'(rsp_valid), 32'd1);
        cmd = mk(3'd2, 3'd0, OP_ADD, C_NONE);
        cmd_valid = 1'b1;
        tick();
        cmd = mk(3'd3, 3'd0, OP_ADD, C_NONE);
        tick();
        cmd_valid = 1'b0;
        cmd = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_alsu_rst", 32'(alsu_rst), 32'd1);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_pins", 32'({alsu_A, alsu_B, alsu_opcode, alsu_ctrl}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel2_edge1", 32'(alsu_rst), 32'd1);
        tick();
        chk("rel2_edge2", 32'(alsu_rst), 32'd0);
        rsp_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid) stale++;
            tick();
        end
        chk("no_stale", 32'(stale), 32'd0);

        // Idle cycles after an op: pins zero, nothing captured.
        send(mk(3'd1, 3'd1, OP_ADD, C_CIN));
        chk("op_on_pins", 32'({alsu_A, alsu_B, alsu_opcode, alsu_ctrl}),
            32'({3'd1, 3'd1, OP_ADD, C_CIN}));
        wait_rsp(lat);
        chk("idle_op_out", 32'(rsp.out), 32'h03);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("idle%0d_pins", k),
                32'({alsu_A, alsu_B, alsu_opcode, alsu_ctrl}), 32'd0);
            chk($sformatf("idle%0d_empty", k), 32'(rsp_valid), 32'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
